// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg
// Shared definitions for the sequential multiplier: controller state
// encoding, operation mode constants and the Booth pair decode values
// used when classifying {Q[0], q_prev}.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_UNSIGNED = 1'b0;
    localparam logic MODE_SIGNED   = 1'b1;

    // {Q[0], q_prev}: 01 ends a run of ones (add M), 10 starts one (subtract M).
    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/seq_mult_ctrl.sv
// seq_mult_ctrl
// Controller for the sequential multiplier: state register, iteration
// counter, Moore handshake outputs and datapath enables.
//
// Ports:
//   clock, reset   rising-edge clock, asynchronous active-high reset
//   start          operation request, honoured only while ready is high
//   zero_op        a zero operand was presented (tied low when zero skip is off)
//   ready/busy/done  handshake outputs decoded from state only
//   load           capture operands into the datapath this edge
//   step           perform one shift-add / Booth iteration this edge
//   last           this edge performs the final iteration; write product
//   skip           zero operand accepted; write product = 0 and go to DONE
module seq_mult_ctrl
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic zero_op,
    output logic ready,
    output logic busy,
    output logic done,
    output logic load,
    output logic step,
    output logic last,
    output logic skip
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;

    // State and remaining-iteration counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            if (load) begin
                cnt <= CNT_W'(WIDTH);
            end else if (step) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    // Handshake outputs depend on state alone; acceptance is shared by
    // IDLE and DONE so back-to-back operations need no IDLE cycle.
    always_comb begin
        next_state = state;
        ready      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        load       = 1'b0;
        step       = 1'b0;
        last       = 1'b0;
        skip       = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
            end
            RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (cnt == CNT_W'(1)) begin
                    last       = 1'b1;
                    next_state = DONE;
                end
            end
            DONE: begin
                ready      = 1'b1;
                done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        if (ready && start) begin
            load = 1'b1;
            if (zero_op) begin
                skip       = 1'b1;
                next_state = DONE;
            end else begin
                next_state = RUN;
            end
        end
    end

endmodule

// File: rtl/seq_multiplier.sv
// seq_multiplier
// Sequential multiplier, one iteration per clock: unsigned shift-add or
// signed radix-2 Booth, chosen per operation with signed_mode.
//
// Ports:
//   clock, reset   rising-edge clock, asynchronous active-high reset
//   start          request; accepted on an edge where ready=1
//   signed_mode    1 = two's-complement Booth, 0 = unsigned (sampled with start)
//   a, b           multiplicand / multiplier (sampled with start)
//   product        2*WIDTH result, held until the next accepted start
//   ready          high in IDLE and DONE
//   busy           high while iterating
//   done           one-cycle pulse when the result is written
//
// Build option: define SEQ_MULT_ZERO_SKIP_EN to finish operations with a
// zero operand in a single cycle.
module seq_multiplier
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product,
    output logic               ready,
    output logic               busy,
    output logic               done
);

    logic             load;
    logic             step;
    logic             last;
    logic             skip;
    logic             zero_op;

    logic [WIDTH-1:0] m;
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] q;
    logic             q_prev;
    logic             mode;

    logic [WIDTH:0]   m_ext;
    logic [WIDTH:0]   acc_sum;
    logic [WIDTH:0]   acc_next;
    logic [WIDTH-1:0] q_next;

`ifdef SEQ_MULT_ZERO_SKIP_EN
    assign zero_op = (a == '0) || (b == '0);
`else
    assign zero_op = 1'b0;
`endif

    seq_mult_ctrl #(
        .WIDTH (WIDTH)
    ) u_ctrl (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .zero_op (zero_op),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .load    (load),
        .step    (step),
        .last    (last),
        .skip    (skip)
    );

    // One iteration. Acc carries an extra bit so that subtracting the most
    // negative multiplicand cannot overflow; the shift fills with that bit
    // in signed mode and with zero in unsigned mode.
    always_comb begin
        m_ext   = {1'b0, m};
        acc_sum = acc;
        if (mode == MODE_SIGNED) begin
            m_ext = {m[WIDTH-1], m};
            case ({q[0], q_prev})
                BOOTH_ADD: acc_sum = acc + m_ext;
                BOOTH_SUB: acc_sum = acc - m_ext;
                default:   acc_sum = acc;
            endcase
            acc_next = {acc_sum[WIDTH], acc_sum[WIDTH:1]};
        end else begin
            if (q[0]) begin
                acc_sum = acc + m_ext;
            end
            acc_next = {1'b0, acc_sum[WIDTH:1]};
        end
        q_next = {acc_sum[0], q[WIDTH-1:1]};
    end

    // Working registers: captured on acceptance, advanced while running.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            m      <= '0;
            acc    <= '0;
            q      <= '0;
            q_prev <= 1'b0;
            mode   <= MODE_UNSIGNED;
        end else if (load) begin
            m      <= a;
            acc    <= '0;
            q      <= b;
            q_prev <= 1'b0;
            mode   <= signed_mode;
        end else if (step) begin
            acc    <= acc_next;
            q      <= q_next;
            q_prev <= q[0];
        end
    end

    // Result register, written from the final iteration's shifted value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            product <= '0;
        end else if (skip) begin
            product <= '0;
        end else if (last) begin
            product <= {acc_next[WIDTH-1:0], q_next};
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier
// Self-checking bench for seq_multiplier (WIDTH=8): directed vectors,
// randomized operations against an arithmetic reference, back-to-back
// operation with start held high, reset during an operation, and zero
// operands (with or without SEQ_MULT_ZERO_SKIP_EN).
module tb_seq_multiplier;

    localparam int W = 8;

    logic           clock;
    logic           reset;
    logic           start;
    logic           signed_mode;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] product;
    logic           ready;
    logic           busy;
    logic           done;

    int checks = 0;
    int fails  = 0;

    seq_multiplier #(
        .WIDTH (W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
        .product     (product),
        .ready       (ready),
        .busy        (busy),
        .done        (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference product computed with plain integer arithmetic.
    function automatic logic [2*W-1:0] ref_mult(input logic [W-1:0] x,
                                                input logic [W-1:0] y,
                                                input logic s);
        int rx;
        int ry;
        if (s) begin
            rx = int'($signed(x));
            ry = int'($signed(y));
        end else begin
            rx = int'({24'd0, x});
            ry = int'({24'd0, y});
        end
        return 16'(rx * ry);
    endfunction

    // Issues one operation from IDLE, scrambles the inputs right after the
    // acceptance edge, and reports the number of edges after acceptance at
    // which done was seen (-1 on timeout) and how many cycles busy was high.
    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic im, output logic [2*W-1:0] res,
                          output int edge_k, output int busy_cycles);
        @(negedge clock);
        a = ia;
        b = ib;
        signed_mode = im;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        signed_mode = ~im;
        edge_k = -1;
        busy_cycles = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (done) begin
                edge_k = k;
                break;
            end
            if (busy) busy_cycles++;
            @(posedge clock);
        end
        res = product;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        signed_mode = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(negedge clock);
        checks++;
        if (product !== 16'h0000) begin
            fails++;
            $display("[TB] FAIL reset_product got=%h exp=0000", product);
        end
        checks++;
        if ({ready, busy, done} !== 3'b100) begin
            fails++;
            $display("[TB] FAIL reset_flags got rbd=%b exp=100", {ready, busy, done});
        end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_directed();
        logic [2*W-1:0] res;
        int ek;
        int bc;
        logic [W-1:0] va [4] = '{8'hFF, 8'h80, 8'hFD, 8'hFD};
        logic [W-1:0] vb [4] = '{8'hFF, 8'h80, 8'h05, 8'h05};
        logic         vm [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [2*W-1:0] ve [4] = '{16'hFE01, 16'h4000, 16'hFFF1, 16'h04F1};
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], vb[i], vm[i], res, ek, bc);
            checks++;
            if (res !== ve[i]) begin
                fails++;
                $display("[TB] FAIL directed_%0d product got=%h exp=%h", i, res, ve[i]);
            end
            checks++;
            if (ek != W) begin
                fails++;
                $display("[TB] FAIL directed_%0d done_edge got=%0d exp=%0d", i, ek, W);
            end
            checks++;
            if (bc != W) begin
                fails++;
                $display("[TB] FAIL directed_%0d busy_cycles got=%0d exp=%0d", i, bc, W);
            end
        end
    endtask

    task automatic test_random();
        logic [2*W-1:0] res;
        logic [2*W-1:0] exp_p;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int ek;
        int bc;
        for (int md = 0; md < 2; md++) begin
            for (int i = 0; i < 1000; i++) begin
                ra = 8'($urandom);
                rb = 8'($urandom);
`ifdef SEQ_MULT_ZERO_SKIP_EN
                if (ra == '0) ra = 8'h01;
                if (rb == '0) rb = 8'h01;
`endif
                exp_p = ref_mult(ra, rb, md[0]);
                run_op(ra, rb, md[0], res, ek, bc);
                checks++;
                if (res !== exp_p || ek != W) begin
                    fails++;
                    $display("[TB] FAIL random mode=%0d a=%h b=%h got=%h exp=%h done_edge=%0d",
                             md, ra, rb, res, exp_p, ek);
                end
            end
        end
    endtask

    // start held high with fresh operands every cycle: a new operation is
    // accepted every W+1 edges (in IDLE, then directly from DONE).
    task automatic test_back_to_back();
        logic [2*W-1:0] exp_q[$];
        logic [2*W-1:0] exp_p;
        int ph;
        @(negedge clock);
        start = 1'b1;
        a = 8'($urandom_range(255, 1));
        b = 8'($urandom_range(255, 1));
        signed_mode = 1'($urandom);
        for (int e = 0; e < 5 * (W + 1); e++) begin
            ph = e % (W + 1);
            if (ph == 0) exp_q.push_back(ref_mult(a, b, signed_mode));
            @(posedge clock);
            @(negedge clock);
            checks++;
            if (done !== (ph == W) || busy !== (ph != W)) begin
                fails++;
                $display("[TB] FAIL b2b_flags edge=%0d got done=%b busy=%b exp done=%b",
                         e, done, busy, ph == W);
            end
            if (ph == W) begin
                exp_p = exp_q.pop_front();
                checks++;
                if (product !== exp_p) begin
                    fails++;
                    $display("[TB] FAIL b2b_product edge=%0d got=%h exp=%h", e, product, exp_p);
                end
            end
            a = 8'($urandom_range(255, 1));
            b = 8'($urandom_range(255, 1));
            signed_mode = 1'($urandom);
        end
        start = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset_mid_run();
        logic [2*W-1:0] res;
        int ek;
        int bc;
        int seen_done;
        run_op(8'd3, 8'd5, 1'b0, res, ek, bc);
        @(negedge clock);
        a = 8'd100;
        b = 8'd7;
        signed_mode = 1'b0;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        checks++;
        if (product !== 16'h0000) begin
            fails++;
            $display("[TB] FAIL midrst_product got=%h exp=0000", product);
        end
        checks++;
        if ({ready, busy, done} !== 3'b100) begin
            fails++;
            $display("[TB] FAIL midrst_flags got rbd=%b exp=100", {ready, busy, done});
        end
        @(negedge clock);
        reset = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (done) seen_done++;
        end
        checks++;
        if (seen_done != 0) begin
            fails++;
            $display("[TB] FAIL midrst_no_done got=%0d pulses exp=0", seen_done);
        end
        run_op(8'hC3, 8'h5A, 1'b1, res, ek, bc);
        checks++;
        if (res !== ref_mult(8'hC3, 8'h5A, 1'b1) || ek != W) begin
            fails++;
            $display("[TB] FAIL midrst_next_op got=%h exp=%h done_edge=%0d",
                     res, ref_mult(8'hC3, 8'h5A, 1'b1), ek);
        end
    endtask

    task automatic test_zero();
        logic [2*W-1:0] res;
        int ek;
        int bc;
        int exp_edge;
`ifdef SEQ_MULT_ZERO_SKIP_EN
        exp_edge = 0;
`else
        exp_edge = W;
`endif
        run_op(8'h12, 8'h34, 1'b0, res, ek, bc);
        run_op(8'h00, 8'h7F, 1'b0, res, ek, bc);
        checks++;
        if (res !== 16'h0000) begin
            fails++;
            $display("[TB] FAIL zero_product got=%h exp=0000", res);
        end
        checks++;
        if (ek != exp_edge) begin
            fails++;
            $display("[TB] FAIL zero_done_edge got=%0d exp=%0d", ek, exp_edge);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid_run();
        test_zero();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
